// File: rtl/fmq_pkg.sv
// Shared constants, parser state encoding and reset offset formula for offset_loader.
package fmq_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] ACK_BYTE   = 8'h06;
    localparam logic [7:0] NAK_BYTE   = 8'h15;
    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_COMMIT = 8'h02;
    localparam logic [7:0] CMD_READ   = 8'h03;

    typedef enum logic [3:0] {
        ST_HUNT,
        ST_GET_CMD,
        ST_GET_CH,
        ST_GET_B2,
        ST_GET_B1,
        ST_GET_B0,
        ST_GET_CHK,
        ST_EXEC,
        ST_RESP
    } parse_state_e;

    function automatic int default_offset(input int slot);
        return slot * 10;
    endfunction

endpackage

// File: rtl/offset_resp_tx.sv
// Response serialiser: loads up to 4 bytes (first byte in the MSBs) and presents them
// one at a time on a valid/ready stream; done pulses on the last handshake.
module offset_resp_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*DATA_WIDTH-1:0] load_bytes,
    input  logic [2:0]              load_count,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    done
);

    localparam int BUF_W = 4 * DATA_WIDTH;

    logic [BUF_W-1:0]      shift_q, shift_d;
    logic [2:0]            left_q, left_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  handshake;

    assign handshake = tx_valid_q && tx_ready;
    assign done      = handshake && (left_q == 3'd1);
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;

    always_comb begin
        shift_d    = shift_q;
        left_d     = left_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (load) begin
            tx_data_d  = load_bytes[BUF_W-1 -: DATA_WIDTH];
            shift_d    = load_bytes << DATA_WIDTH;
            left_d     = load_count;
            tx_valid_d = (load_count != 3'd0);
        end else if (handshake) begin
            if (left_q > 3'd1) begin
                tx_data_d = shift_q[BUF_W-1 -: DATA_WIDTH];
                shift_d   = shift_q << DATA_WIDTH;
                left_d    = left_q - 3'd1;
            end else begin
                left_d     = 3'd0;
                tx_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q    <= '0;
            left_q     <= 3'd0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            shift_q    <= shift_d;
            left_q     <= left_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

endmodule

// File: rtl/offset_loader.sv
// UART frame parser driving a shadow/active phase-offset bank and the reload line.
// Optional inter-byte timeout is enabled by defining OFFSET_LOADER_TIMEOUT_EN.
module offset_loader
    import fmq_pkg::*;
#(
    parameter int OUTPUTS      = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int OFFSET_WIDTH = 24,
    parameter int MAX_OFFSET   = 1249,
    parameter int TIMEOUT      = 500000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           rx_data,
    input  logic                            rx_valid,
    output logic                            rx_ready,
    output logic [DATA_WIDTH-1:0]           tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic [OFFSET_WIDTH*OUTPUTS-1:0] offsets,
    output logic                            reload
);

    localparam int SLOT_W = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1;

    parse_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] cmd_q, cmd_d, ch_q, ch_d, xor_q, xor_d, chk_q, chk_d;
    logic [OFFSET_WIDTH-1:0] off_q, off_d;
    logic [OFFSET_WIDTH-1:0] shadow_q [OUTPUTS];
    logic [OFFSET_WIDTH-1:0] shadow_d [OUTPUTS];
    logic [OFFSET_WIDTH-1:0] active_q [OUTPUTS];
    logic [OFFSET_WIDTH-1:0] active_d [OUTPUTS];
    logic                  reload_q, reload_d;
    logic                  rx_ready_q, rx_ready_d;

    logic                    rx_fire, cmd_known, frame_bad, timeout_hit;
    logic [SLOT_W-1:0]       slot;
    logic                    resp_load, resp_done;
    logic [4*DATA_WIDTH-1:0] resp_bytes;
    logic [2:0]              resp_count;

    assign rx_fire   = rx_valid && rx_ready_q;
    assign rx_ready  = rx_ready_q;
    assign reload    = reload_q;
    assign slot      = ch_q[SLOT_W-1:0];
    assign cmd_known = cmd_q inside {CMD_WRITE, CMD_COMMIT, CMD_READ};
    // All NAK causes collapse into one flag since they share a single reply.
    assign frame_bad = (xor_q != chk_q) || !cmd_known
                    || (cmd_q != CMD_COMMIT && int'(ch_q) >= OUTPUTS)
                    || (cmd_q == CMD_WRITE && int'(off_q) > MAX_OFFSET);

`ifdef OFFSET_LOADER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            in_get;

    assign in_get      = state_q inside {ST_GET_CMD, ST_GET_CH, ST_GET_B2, ST_GET_B1,
                                         ST_GET_B0, ST_GET_CHK};
    assign timeout_hit = in_get && !rx_fire && (to_cnt_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        to_cnt_d = '0;
        if (in_get && !rx_fire) to_cnt_d = to_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) to_cnt_q <= '0;
        else      to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets its hold value first so no branch can infer a latch.
        state_d    = state_q;
        cmd_d      = cmd_q;
        ch_d       = ch_q;
        off_d      = off_q;
        xor_d      = xor_q;
        chk_d      = chk_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        reload_d   = 1'b1;
        resp_load  = 1'b0;
        resp_bytes = {NAK_BYTE, {OFFSET_WIDTH{1'b0}}};
        resp_count = 3'd1;

        case (state_q)
            ST_HUNT: begin
                if (rx_fire && rx_data == SYNC_BYTE) begin
                    xor_d   = '0;
                    state_d = ST_GET_CMD;
                end
            end
            ST_GET_CMD: begin
                if (rx_fire) begin
                    cmd_d   = rx_data;
                    xor_d   = xor_q ^ rx_data;
                    state_d = ST_GET_CH;
                end
            end
            ST_GET_CH: begin
                if (rx_fire) begin
                    ch_d    = rx_data;
                    xor_d   = xor_q ^ rx_data;
                    state_d = ST_GET_B2;
                end
            end
            ST_GET_B2, ST_GET_B1, ST_GET_B0: begin
                if (rx_fire) begin
                    off_d   = {off_q[OFFSET_WIDTH-DATA_WIDTH-1:0], rx_data};
                    xor_d   = xor_q ^ rx_data;
                    state_d = (state_q == ST_GET_B2) ? ST_GET_B1 :
                              (state_q == ST_GET_B1) ? ST_GET_B0 : ST_GET_CHK;
                end
            end
            ST_GET_CHK: begin
                if (rx_fire) begin
                    chk_d   = rx_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                resp_load = 1'b1;
                state_d   = ST_RESP;
                if (!frame_bad) begin
                    resp_bytes = {ACK_BYTE, {OFFSET_WIDTH{1'b0}}};
                    case (cmd_q)
                        CMD_WRITE:  shadow_d[slot] = off_q;
                        CMD_COMMIT: begin
                            active_d = shadow_q;
                            reload_d = 1'b0;
                        end
                        default: begin
                            resp_bytes = {ACK_BYTE, shadow_q[slot]};
                            resp_count = 3'd4;
                        end
                    endcase
                end
            end
            ST_RESP: begin
                if (resp_done) state_d = ST_HUNT;
            end
            default: state_d = ST_HUNT;
        endcase

        if (timeout_hit) state_d = ST_HUNT;
        rx_ready_d = !(state_d inside {ST_EXEC, ST_RESP});
    end

    always_comb begin
        offsets = '0;
        for (int i = 0; i < OUTPUTS; i++) offsets[OFFSET_WIDTH*i +: OFFSET_WIDTH] = active_q[i];
    end

    // NOTE: the offset banks are small flop arrays with defined power-up contents, so they are reset like any other state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_HUNT;
            cmd_q      <= '0;
            ch_q       <= '0;
            off_q      <= '0;
            xor_q      <= '0;
            chk_q      <= '0;
            reload_q   <= 1'b0;
            rx_ready_q <= 1'b0;
            for (int i = 0; i < OUTPUTS; i++) begin
                shadow_q[i] <= OFFSET_WIDTH'(default_offset(i));
                active_q[i] <= OFFSET_WIDTH'(default_offset(i));
            end
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            ch_q       <= ch_d;
            off_q      <= off_d;
            xor_q      <= xor_d;
            chk_q      <= chk_d;
            reload_q   <= reload_d;
            rx_ready_q <= rx_ready_d;
            shadow_q   <= shadow_d;
            active_q   <= active_d;
        end
    end

    offset_resp_tx #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_resp_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (resp_load),
        .load_bytes(resp_bytes),
        .load_count(resp_count),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (resp_done)
    );

endmodule

// File: tb/tb_offset_loader.sv
// Directed bench for offset_loader: transaction-level bank/response model plus literal pins.
module tb_offset_loader;

    localparam int OUTPUTS    = 16;
    localparam int DW         = 8;
    localparam int OW         = 24;
    localparam int MAXO       = 1249;
    localparam int TB_TIMEOUT = 100;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [DW-1:0]         rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [DW-1:0]         tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [OW*OUTPUTS-1:0] offsets;
    logic                  reload;

    offset_loader #(
        .OUTPUTS(OUTPUTS), .DATA_WIDTH(DW), .OFFSET_WIDTH(OW),
        .MAX_OFFSET(MAXO), .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .offsets(offsets), .reload(reload)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    int         m_shadow [OUTPUTS];
    int         m_active [OUTPUTS];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    bit         mon_en = 1'b0;
    int         reload_lows = 0;
    bit         prev_stall = 1'b0;
    bit         prev_reload_low = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] slot(input int i);
        return offsets[OW*i +: OW];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < OUTPUTS; i++) begin
            m_shadow[i] = i * 10;
            m_active[i] = i * 10;
        end
        exp_q.delete();
    endfunction

    function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] ch,
                                             input logic [23:0] off);
        return cmd ^ ch ^ off[23:16] ^ off[15:8] ^ off[7:0];
    endfunction

    // Frame semantics at transaction level: decide reply bytes and bank effects.
    function automatic void model_frame(input logic [7:0] cmd, input logic [7:0] ch,
                                        input logic [23:0] off, input logic [7:0] chk);
        bit bad;
        bad = (chk != frame_chk(cmd, ch, off)) || (cmd < 8'd1) || (cmd > 8'd3)
           || (cmd != 8'd2 && ch >= OUTPUTS) || (cmd == 8'd1 && off > MAXO);
        if (bad) begin
            exp_q.push_back(8'h15);
        end else if (cmd == 8'd1) begin
            m_shadow[ch] = int'(off);
            exp_q.push_back(8'h06);
        end else if (cmd == 8'd2) begin
            m_active = m_shadow;
            exp_q.push_back(8'h06);
        end else begin
            exp_q.push_back(8'h06);
            exp_q.push_back(8'(m_shadow[ch] >> 16));
            exp_q.push_back(8'(m_shadow[ch] >> 8));
            exp_q.push_back(8'(m_shadow[ch]));
        end
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) check("rx_accept_timeout", 32'(rx_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] ch,
                              input logic [23:0] off, input logic [7:0] chk_flip);
        logic [7:0] chk;
        chk = frame_chk(cmd, ch, off) ^ chk_flip;
        model_frame(cmd, ch, off, chk);
        send_byte(8'hA5);
        send_byte(cmd);
        send_byte(ch);
        send_byte(off[23:16]);
        send_byte(off[15:8]);
        send_byte(off[7:0]);
        send_byte(chk);
        @(negedge clk);
        rx_valid = 1'b0;
        check("exec_tx_idle", 32'(tx_valid), 32'd0);
        check("exec_rx_ready", 32'(rx_ready), 32'd0);
        @(negedge clk);
        check("first_byte_valid", 32'(tx_valid), 32'd1);
    endtask

    task automatic wait_resp();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("resp_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_banks(input string tag);
        for (int i = 0; i < OUTPUTS; i++) check(tag, 32'(slot(i)), 32'(m_active[i]));
    endtask

    task automatic check_single(input string tag, input logic [7:0] b);
        check({tag, "_count"}, 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check(tag, 32'(got_q[0]), 32'(b));
    endtask

    // Compare process: response bytes, hold-under-backpressure and reload pulse shape.
    always begin
        @(negedge clk);
        #1;
        if (mon_en) begin
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected actual=%02h required=none at %0t", tx_data, $time);
                end else begin
                    check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
            end
            if (prev_stall) begin
                check("tx_hold_valid", 32'(tx_valid), 32'd1);
                check("tx_hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (!reload) begin
                reload_lows++;
                check("reload_single_cycle", 32'(prev_reload_low), 32'd0);
                check("ack_with_reload", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h06});
            end
            prev_stall      = tx_valid && !tx_ready;
            prev_data       = tx_data;
            prev_reload_low = !reload;
        end else begin
            prev_stall      = 1'b0;
            prev_reload_low = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_rd [4];
        logic [7:0] held;
        int         lows0;

        rst = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_slot3", 32'(slot(3)), 32'd30);
        check("rst_slot15", 32'(slot(15)), 32'd150);
        check("rst_reload", 32'(reload), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check_banks("rst_bank");

        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("release_reload_low", 32'(reload), 32'd0);
        check("release_rx_ready_low", 32'(rx_ready), 32'd0);
        @(negedge clk);
        check("release_reload_high", 32'(reload), 32'd1);
        check("release_rx_ready_high", 32'(rx_ready), 32'd1);
        check("release_no_tx", 32'(tx_valid), 32'd0);
        mon_en = 1'b1;

        // Write slot 5 = 500, then read it back from the shadow bank.
        got_q.delete();
        send_frame(8'h01, 8'h05, 24'h0001F4, 8'h00);
        wait_resp();
        check_single("write_ack", 8'h06);
        got_q.delete();
        send_frame(8'h03, 8'h05, 24'h000000, 8'h00);
        wait_resp();
        exp_rd = '{8'h06, 8'h00, 8'h01, 8'hF4};
        check("read_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < got_q.size()) check("read_byte", 32'(got_q[i]), 32'(exp_rd[i]));
        check("active5_pre_commit", 32'(slot(5)), 32'd50);

        // Commit copies shadow to active with a single reload pulse.
        lows0 = reload_lows;
        send_frame(8'h02, 8'h00, 24'h000000, 8'h00);
        wait_resp();
        check("active5_post_commit", 32'(slot(5)), 32'd500);
        check("reload_pulses", 32'(reload_lows - lows0), 32'd1);
        check_banks("commit_bank");

        // Error frames: each a single NAK, no bank change.
        got_q.delete();
        send_frame(8'h01, 8'h00, 24'd1250, 8'h00);
        wait_resp();
        check_single("nak_range", 8'h15);
        got_q.delete();
        send_frame(8'h01, 8'h10, 24'h000001, 8'h00);
        wait_resp();
        check_single("nak_channel", 8'h15);
        got_q.delete();
        send_frame(8'h01, 8'h02, 24'h000007, 8'h5A);
        wait_resp();
        check_single("nak_chk", 8'h15);
        got_q.delete();
        send_frame(8'h07, 8'h01, 24'h000001, 8'h00);
        wait_resp();
        check_single("nak_cmd", 8'h15);
        check_banks("error_bank");
        send_frame(8'h03, 8'h00, 24'h000000, 8'h00);
        wait_resp();
        send_frame(8'h03, 8'h02, 24'h000000, 8'h00);
        wait_resp();

        // Noise ahead of a frame is dropped.
        send_byte(8'h00);
        send_byte(8'hFF);
        got_q.delete();
        send_frame(8'h03, 8'h03, 24'h000000, 8'h00);
        wait_resp();
        check("noise_read_lsb", 32'(got_q.size() == 4 ? got_q[3] : 8'hXX), 32'h1E);

        // Backpressure during a READ response.
        tx_ready = 1'b0;
        send_frame(8'h03, 8'h05, 24'h000000, 8'h00);
        held = tx_data;
        check("bp_first_byte", 32'(held), 32'h06);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_rx_ready", 32'(rx_ready), 32'd0);
            check("bp_tx_stable", 32'(tx_data), 32'(held));
        end
        tx_ready = 1'b1;
        wait_resp();

        // Reset mid-frame discards the partial frame and restores defaults.
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h05);
        @(negedge clk);
        mon_en = 1'b0;
        rx_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_slot5", 32'(slot(5)), 32'd50);
        check("midrst_tx_valid", 32'(tx_valid), 32'd0);
        check("midrst_rx_ready", 32'(rx_ready), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        got_q.delete();
        send_frame(8'h03, 8'h05, 24'h000000, 8'h00);
        wait_resp();
        check("midrst_read_lsb", 32'(got_q.size() == 4 ? got_q[3] : 8'hXX), 32'h32);
        check_banks("midrst_bank");

`ifdef OFFSET_LOADER_TIMEOUT_EN
        // Partial frame abandoned after TIMEOUT idle cycles.
        send_byte(8'hA5);
        send_byte(8'h01);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (TB_TIMEOUT) @(posedge clk);
        got_q.delete();
        send_frame(8'h01, 8'h07, 24'd77, 8'h00);
        wait_resp();
        check_single("timeout_ack", 8'h06);
        send_frame(8'h03, 8'h07, 24'h000000, 8'h00);
        wait_resp();
`endif

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/offset_loader.md
# offset_loader

Command stage that feeds the transducer clock bank. Consumes bytes from the UART receive stream, parses fixed-length phase-offset frames, keeps a shadow offset bank and an active offset bank, and drives the flat `offsets` bus and the `reload` line into the per-output clock generators. Answers every complete frame with ACK, NAK or read-back bytes on the UART transmit stream.

## Interface
- `OUTPUTS`, 16: number of clock generators and offset slots.
- `DATA_WIDTH`, 8: UART byte width.
- `OFFSET_WIDTH`, 24: bits per offset slot.
- `MAX_OFFSET`, 1249: largest legal offset, one full 40 kHz period at 50 MHz minus 1.
- `TIMEOUT`, 500000: inter-byte timeout in clk cycles (10 ms).
- `clk` in 1: system clock.
- `rst` in 1: one clock; reset is asynchronous and active-low.
- `rx_data` in DATA_WIDTH: received byte.
- `rx_valid` in 1: received byte valid.
- `rx_ready` out 1: byte accepted when `rx_valid && rx_ready`.
- `tx_data` out DATA_WIDTH: response byte.
- `tx_valid` out 1: response byte valid.
- `tx_ready` in 1: response byte taken when `tx_valid && tx_ready`.
- `offsets` out OFFSET_WIDTH*OUTPUTS: active bank; slot i at `[OFFSET_WIDTH*i +: OFFSET_WIDTH]`.
- `reload` out 1: active-low generator resync.

## Operation
- Frame, 7 bytes: SYNC 0xA5, CMD, CH, B2, B1, B0, CHK. Offset = {B2,B1,B0}, MSB first. CHK = XOR of CMD, CH, B2, B1, B0.
- CMD 0x01 WRITE: shadow[CH] <= offset. Reply ACK 0x06.
- CMD 0x02 COMMIT: active <= shadow (all slots), `reload` pulses low. CH and offset are ignored. Reply ACK.
- CMD 0x03 READ: reply ACK, then shadow[CH] as 3 bytes, MSB first.
- NAK 0x15, with no state change, on: bad CHK; unknown CMD; CH >= OUTPUTS (WRITE/READ); offset > MAX_OFFSET (WRITE). The check order is CHK, then CMD, then CH, then range. All failures give the same single NAK.
- States: HUNT, GET_CMD, GET_CH, GET_B2, GET_B1, GET_B0, GET_CHK, EXEC, RESP.
  - HUNT: non-0xA5 bytes are silently dropped. 0xA5 -> GET_CMD.
  - Each GET_* advances on an accepted byte. GET_CHK -> EXEC.
  - EXEC (1 cycle): validate, apply, load the response count (1 or 4) -> RESP.
  - RESP: each handshake emits the next byte. After the last byte -> HUNT.
- A 0xA5 received mid-frame is treated as data and does not resync.
- `rx_ready` is 1 in HUNT and GET_*, and 0 in EXEC and RESP.
- Reset values:
  - slot i of shadow and active = i*10.
  - `reload` 0.
  - `rx_ready` 0, `tx_valid` 0, `tx_data` 0.
  - state HUNT.
- Reset asserted mid-frame or mid-response: everything returns to the reset values at once, and any partial frame is lost.

## Timing
- First clk after `rst` rises: `reload` -> 1 and `rx_ready` -> 1.
- CHK accepted at edge N: EXEC during cycle N+1. `tx_valid`=1 with the first byte from edge N+2.
- COMMIT:
  - `offsets` updates at edge N+2.
  - `reload`=0 for exactly the cycle after N+2, then back to 1.
  - The ACK is presented in parallel with this pulse.
- `tx_data` is stable while `tx_valid && !tx_ready`. The next byte is presented the cycle after a handshake.
- READ of a slot already written in the same stream returns the shadow value, not the active value.
- Back-to-back frames: the first SYNC of the next frame can be accepted the cycle after the last response handshake.

## Configuration
- `OFFSET_LOADER_TIMEOUT_EN` defined:
  - A counter restarts on every accepted byte.
  - If TIMEOUT cycles elapse in any GET_* state, the FSM returns to HUNT with no reply and no state change.
  - The counter is held in HUNT, EXEC and RESP.
- Macro undefined: no counter. A partial frame waits indefinitely.

## Structure
- Package `fmq_pkg` holds:
  - SYNC, ACK, NAK and CMD code constants.
  - the parser state enum.
  - the default offset formula (i*10).
- One sub-module, `offset_resp_tx`: a 4-byte response serialiser with a load strobe, byte count and valid/ready output. It keeps the RESP handshake out of the parser FSM.

## Test plan
- Reset release: `offsets` slot 3 = 30, slot 15 = 150. `reload` 0 then 1 one cycle after release. No tx traffic.
- Write then read: A5 01 05 00 01 F4 F1 -> ACK. Then A5 03 05 00 00 00 06 -> 06 00 01 F4. Active slot 5 is still 50.
- Commit: after the write above, A5 02 00 00 00 00 02 -> ACK. Active slot 5 = 500. `reload` low exactly 1 cycle. Other slots unchanged.
- Errors, each giving a single NAK 0x15 and unchanged banks:
  - write of 1250 (A5 01 00 00 04 E2 E7).
  - CH = 16 (A5 01 10 00 00 01 10).
  - corrupted CHK.
- Backpressure and noise:
  - 00 FF A5 prefix bytes are dropped and the frame is parsed.
  - Hold `tx_ready` low 20 cycles during READ: `tx_data` stable and `rx_ready` 0 throughout.
- Timeout (macro on, TIMEOUT=100): send A5 01, idle 100 cycles, then send a full valid frame -> exactly one ACK, and the partial frame is discarded.
